// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared state encoding and width helpers for the UART TX arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_LOCKED = 2'd3
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// rtl/uart_arb_pick.sv - combinational round-robin picker, search starts just after last.
module uart_arb_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          win_valid
);

  logic [IW-1:0] cand;

  always_comb begin
    win_oh    = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!win_valid && req[cand]) begin
        win_valid    = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one UART transmitter among N byte requesters.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int N           = 4,
  parameter int LockTimeout = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     more,
  input  logic [8*N-1:0]   data,
  output logic [N-1:0]     ack,
  output logic [N-1:0]     grant,
  output logic             busy,
  output logic [7:0]       uart_din,
  output logic             uart_send,
  input  logic             uart_txbusy
);

  localparam int IW = idx_width(N);
  localparam int CW = cnt_width(LockTimeout);
  localparam logic LOCK_EN = (LockTimeout != 0);
  localparam logic [CW-1:0] CNT_MAX = CW'(LockTimeout);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [7:0]    din_q, din_d;
  logic          lock_q, lock_d;
  logic          send_q, send_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  pick_oh;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  uart_arb_pick #(.N(N), .IW(IW)) u_pick (
    .req       (req),
    .last      (last_q),
    .win_oh    (pick_oh),
    .win_idx   (pick_idx),
    .win_valid (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    grant_d = grant_q;
    ack_d   = '0;
    din_d   = din_q;
    lock_d  = lock_q;
    send_d  = send_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // A byte may still be leaving the UART after reset, so never grant over txbusy.
        if (!uart_txbusy && pick_valid) begin
          owner_d = pick_idx;
          grant_d = pick_oh;
          ack_d   = pick_oh;
          din_d   = data[8*pick_idx +: 8];
          lock_d  = LOCK_EN & more[pick_idx];
          send_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (uart_txbusy) begin
          send_d  = 1'b0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!uart_txbusy) begin
          if (!lock_q) begin
            grant_d = '0;
            last_d  = owner_q;
            state_d = ST_IDLE;
          end else if (req[owner_q]) begin
            ack_d   = grant_q;
            din_d   = data[8*owner_q +: 8];
            lock_d  = LOCK_EN & more[owner_q];
            send_d  = 1'b1;
            state_d = ST_SEND;
          end else begin
            cnt_d   = '0;
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        // Only the owner is listened to; the counter stops at CNT_MAX so it cannot wrap.
        if (req[owner_q]) begin
          ack_d   = grant_q;
          din_d   = data[8*owner_q +: 8];
          lock_d  = LOCK_EN & more[owner_q];
          send_d  = 1'b1;
          state_d = ST_SEND;
        end else if (cnt_q == CNT_MAX) begin
          grant_d = '0;
          last_d  = owner_q;
          lock_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(N - 1);
      owner_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      din_q   <= '0;
      lock_q  <= 1'b0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      din_q   <= din_d;
      lock_q  <= lock_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack       = ack_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign uart_din  = din_q;
  assign uart_send = send_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - randomized and directed bench for uart_tx_arb with a behavioural UART and order model.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int LT = 7;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   more = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           busy;
  logic [7:0]     uart_din;
  logic           uart_send;
  logic           uart_txbusy = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arb #(.N(N), .LockTimeout(LT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .more        (more),
    .data        (data),
    .ack         (ack),
    .grant       (grant),
    .busy        (busy),
    .uart_din    (uart_din),
    .uart_send   (uart_send),
    .uart_txbusy (uart_txbusy)
  );

  // Behavioural UART: latches din on send, raises txbusy after a random delay, delivers the byte when done.
  int         m_state = 0;
  int         m_wait  = 0;
  logic [7:0] m_byte  = '0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    case (m_state)
      0: if (uart_send) begin
        m_byte  = uart_din;
        m_wait  = int'($urandom_range(0, 3));
        m_state = 1;
      end
      1: if (m_wait == 0) begin
        uart_txbusy = 1'b1;
        m_wait      = int'($urandom_range(2, 8));
        m_state     = 2;
      end else m_wait = m_wait - 1;
      2: if (m_wait == 0) begin
        uart_txbusy = 1'b0;
        rx_q.push_back(m_byte);
        m_state = 0;
      end else m_wait = m_wait - 1;
      default: m_state = 0;
    endcase
  end

  logic [8:0] pq [N][8];
  int         pn [N];
  int         pi [N];
  logic       act [N];
  int         ack_cnt [N];
  int         multi_ack = 0;
  int         errors = 0;
  int         checks = 0;
  int         m_last = N - 1;
  logic [7:0] exp_q[$];

  task automatic clear_drv();
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0; pn[i] = 0; pi[i] = 0; ack_cnt[i] = 0;
    end
    req  = '0;
    more = '0;
    rx_q.delete();
    exp_q.delete();
  endtask

  // One clock: observe acks, then let every active requester present its next byte.
  task automatic step();
    @(negedge clk);
    #1;
    if ($countones(ack) > 1) multi_ack++;
    for (int i = 0; i < N; i++) begin
      if (ack[i]) ack_cnt[i]++;
      if (act[i]) begin
        if (ack[i]) pi[i]++;
        if (pi[i] < pn[i]) begin
          req[i]          = 1'b1;
          data[8*i +: 8]  = pq[i][pi[i]][7:0];
          more[i]         = pq[i][pi[i]][8];
        end else begin
          req[i]  = 1'b0;
          more[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    bit done;
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      step();
      done = 1'b1;
      for (int i = 0; i < N; i++) if (act[i] && pi[i] < pn[i]) done = 1'b0;
      if (done && !busy && m_state == 0 && !uart_send && !uart_txbusy) ok = 1'b1;
    end
  endtask

  // Expected delivery order from the round-robin and locking rules over the queued bytes.
  task automatic model_order();
    int  left [N];
    int  pos [N];
    int  total;
    int  w;
    int  j;
    bit  hold;
    bit  found;
    total = 0; w = 0; hold = 1'b0;
    for (int i = 0; i < N; i++) begin left[i] = pn[i]; pos[i] = 0; total += pn[i]; end
    while (total > 0) begin
      if (!hold) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (!found && left[j] > 0) begin w = j; found = 1'b1; end
        end
      end
      exp_q.push_back(pq[w][pos[w]][7:0]);
      hold = pq[w][pos[w]][8] && (left[w] > 1);
      pos[w]++; left[w]--; total--;
      if (!hold) m_last = w;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0", grant); end
    checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (uart_send !== 1'b0) begin errors++; $display("FAIL reset_send: got %b expected 0", uart_send); end
    checks++; if (uart_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %h expected 00", uart_din); end
    reset = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    m_last = N - 1;
  endtask

  task automatic test_single();
    bit ok;
    clear_drv();
    req[2] = 1'b1; data[23:16] = 8'hA9; more[2] = 1'b0;
    step();
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", ack); end
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", grant); end
    checks++; if (uart_send !== 1'b1) begin errors++; $display("FAIL single_send: got %b expected 1", uart_send); end
    checks++; if (uart_din !== 8'hA9) begin errors++; $display("FAIL single_din: got %h expected a9", uart_din); end
    req[2] = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle: got timeout expected idle"); end
    checks++; if (ack_cnt[2] !== 1) begin errors++; $display("FAIL single_ack_count: got %0d expected 1", ack_cnt[2]); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA9) begin
      errors++; $display("FAIL single_rx: got %0d bytes first %h expected 1 byte a9", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
    m_last = 2;
  endtask

  task automatic test_round_robin();
    bit ok;
    reset = 1'b0; step(); step(); reset = 1'b1; step();
    m_last = N - 1;
    clear_drv();
    for (int i = 0; i < N; i++) begin pq[i][0] = {1'b0, 8'h10 + 8'(i)}; pn[i] = 1; act[i] = 1'b1; end
    exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr1_idle: got timeout expected idle"); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rr1_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL rr1_byte%0d: got %h expected %h", k, rx_q[k], exp_q[k]); end
    end
    m_last = 3;
    clear_drv();
    for (int i = 0; i < N; i++) begin pq[i][0] = {1'b0, 8'h20 + 8'(i)}; pn[i] = 1; end
    pq[0][1] = {1'b0, 8'h24}; pn[0] = 2;
    model_order();
    for (int i = 0; i < N; i++) act[i] = 1'b1;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr2_idle: got timeout expected idle"); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rr2_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL rr2_byte%0d: got %h expected %h", k, rx_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_lock();
    bit ok;
    int g_bad;
    clear_drv();
    pq[1][0] = {1'b1, 8'h55}; pq[1][1] = {1'b0, 8'h56}; pn[1] = 2; act[1] = 1'b1;
    step();
    pq[0][0] = {1'b0, 8'hAA}; pn[0] = 1; act[0] = 1'b1;
    g_bad = 0;
    for (int n = 0; n < 500 && ack_cnt[1] < 2; n++) begin
      step();
      if (ack_cnt[1] >= 1 && grant !== 4'b0010) g_bad++;
    end
    checks++; if (ack_cnt[1] !== 2) begin errors++; $display("FAIL lock_acks: got %0d expected 2", ack_cnt[1]); end
    checks++; if (g_bad !== 0) begin errors++; $display("FAIL lock_grant_held: got %0d bad cycles expected 0", g_bad); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL lock_idle: got timeout expected idle"); end
    exp_q.push_back(8'h55); exp_q.push_back(8'h56); exp_q.push_back(8'hAA);
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL lock_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL lock_byte%0d: got %h expected %h", k, rx_q[k], exp_q[k]); end
    end
    m_last = 0;
  endtask

  task automatic test_lock_timeout();
    bit ok;
    bit seen_hi;
    bit fell;
    int hold_bad;
    clear_drv();
    pq[1][0] = {1'b1, 8'h55}; pn[1] = 1; act[1] = 1'b1;
    for (int n = 0; n < 200 && ack_cnt[1] < 1; n++) step();
    pq[3][0] = {1'b0, 8'hC3}; pn[3] = 1; act[3] = 1'b1;
    seen_hi = 1'b0; fell = 1'b0;
    for (int n = 0; n < 200 && !fell; n++) begin
      step();
      if (uart_txbusy) seen_hi = 1'b1;
      else if (seen_hi) fell = 1'b1;
    end
    checks++; if (!fell) begin errors++; $display("FAIL timeout_txbusy: got no fall expected fall"); end
    hold_bad = 0;
    for (int k = 1; k <= LT + 1; k++) begin
      step();
      if (grant !== 4'b0010) hold_bad++;
    end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL timeout_hold: got %0d bad cycles expected 0", hold_bad); end
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL timeout_release: got %b expected 0000", grant); end
    step();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL timeout_next_grant: got %b expected 1000", grant); end
    checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL timeout_next_ack: got %b expected 1000", ack); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_idle: got timeout expected idle"); end
    checks++; if (rx_q.size() != 2 || rx_q[0] !== 8'h55 || rx_q[1] !== 8'hC3) begin
      errors++; $display("FAIL timeout_rx: got %0d bytes expected 55 c3", rx_q.size());
    end
    m_last = 3;
  endtask

  task automatic test_withdraw();
    bit ok;
    clear_drv();
    pq[0][0] = {1'b0, 8'h5A}; pn[0] = 1; act[0] = 1'b1;
    for (int n = 0; n < 200 && ack_cnt[0] < 1; n++) step();
    req[3] = 1'b1; data[31:24] = 8'hEE;
    step(); step();
    req[3] = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL withdraw_idle: got timeout expected idle"); end
    checks++; if (ack_cnt[3] !== 0) begin errors++; $display("FAIL withdraw_ack: got %0d expected 0", ack_cnt[3]); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
      errors++; $display("FAIL withdraw_rx: got %0d bytes expected 1 byte 5a", rx_q.size());
    end
    m_last = 0;
  endtask

  task automatic test_reset_mid_byte();
    bit ok;
    bit hit;
    bit prev;
    int bad;
    clear_drv();
    pq[0][0] = {1'b0, 8'h96}; pn[0] = 1; act[0] = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      step();
      if (uart_send && uart_txbusy) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rmid_reach_send: got no send expected send"); end
    reset = 1'b0;
    #1;
    checks++; if (grant !== '0) begin errors++; $display("FAIL rmid_grant: got %b expected 0", grant); end
    checks++; if (ack !== '0) begin errors++; $display("FAIL rmid_ack: got %b expected 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    checks++; if (uart_send !== 1'b0) begin errors++; $display("FAIL rmid_send: got %b expected 0", uart_send); end
    checks++; if (uart_din !== 8'h00) begin errors++; $display("FAIL rmid_din: got %h expected 00", uart_din); end
    act[0] = 1'b0;
    pq[2][0] = {1'b0, 8'h3C}; pn[2] = 1; act[2] = 1'b1;
    step(); step();
    checks++; if (ack_cnt[2] !== 0) begin errors++; $display("FAIL rmid_ack_in_reset: got %0d expected 0", ack_cnt[2]); end
    reset = 1'b1;
    bad = 0;
    prev = uart_txbusy;
    for (int n = 0; n < 200 && prev; n++) begin
      step();
      if (grant !== '0) bad++;
      prev = uart_txbusy;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_grant_while_busy: got %0d bad cycles expected 0", bad); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_idle: got timeout expected idle"); end
    checks++; if (ack_cnt[2] !== 1) begin errors++; $display("FAIL rmid_ack_after: got %0d expected 1", ack_cnt[2]); end
    checks++; if (rx_q.size() != 2 || rx_q[0] !== 8'h96 || rx_q[1] !== 8'h3C) begin
      errors++; $display("FAIL rmid_rx: got %0d bytes expected 96 3c", rx_q.size());
    end
    m_last = 2;
  endtask

  task automatic test_random();
    bit ok;
    int total;
    int acks;
    int blen;
    logic mbit;
    for (int r = 0; r < 8; r++) begin
      clear_drv();
      total = 0;
      for (int i = 0; i < N; i++) begin
        pn[i] = int'($urandom_range(0, 3));
        total += pn[i];
      end
      if (total == 0) begin pn[0] = 1; total = 1; end
      for (int i = 0; i < N; i++) begin
        blen = pn[i];
        for (int j = 0; j < blen; j++) begin
          mbit = (j < blen - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          pq[i][j] = {mbit, 8'($urandom_range(0, 255))};
        end
      end
      model_order();
      for (int i = 0; i < N; i++) act[i] = 1'b1;
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_idle: got timeout expected idle", r); end
      acks = 0;
      for (int i = 0; i < N; i++) acks += ack_cnt[i];
      checks++; if (acks !== total) begin errors++; $display("FAIL rand%0d_acks: got %0d expected %0d", r, acks, total); end
      checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", r, rx_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
        checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand%0d_byte%0d: got %h expected %h", r, k, rx_q[k], exp_q[k]); end
      end
    end
    checks++; if (multi_ack !== 0) begin errors++; $display("FAIL multi_ack: got %0d cycles expected 0", multi_ack); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) for (int j = 0; j < 8; j++) pq[i][j] = '0;
    clear_drv();
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_lock_timeout();
    test_withdraw();
    test_reset_mid_byte();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
